// File: rtl/serializer_shift_right_8bit.sv
// Parallel-to-serial stage: accepts a word over valid/ready and shifts it out
// LSB-first through a zero-filling logical right shift, CLKS_PER_BIT clocks per bit.
module serializer_shift_right_8bit #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_idx
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_bit_idx;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_done;

  logic w_bit_end;
  logic w_last_bit;

  assign w_bit_end  = (r_div_cnt == DIV_W'(CLKS_PER_BIT - 1));
  assign w_last_bit = (r_bit_idx == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_div_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_valid) begin
            r_shreg   <= load_data;
            r_bit_idx <= '0;
            r_div_cnt <= '0;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // abort outranks a coinciding final-bit completion, so no done pulse
          if (abort) begin
            r_shreg   <= '0;
            r_bit_idx <= '0;
            r_div_cnt <= '0;
            r_state   <= ST_IDLE;
          end else if (w_bit_end) begin
            r_div_cnt <= '0;
            r_shreg   <= {1'b0, r_shreg[WIDTH-1:1]};
            if (w_last_bit) begin
              r_bit_idx <= '0;
              r_state   <= ST_IDLE;
              r_done    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + CNT_W'(1);
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign load_ready = (r_state == ST_IDLE);
  assign busy       = (r_state == ST_SHIFT);
  assign ser_valid  = (r_state == ST_SHIFT);
  assign ser_out    = (r_state == ST_SHIFT) & r_shreg[0];
  assign done       = r_done;
  assign bit_idx    = r_bit_idx;

endmodule

// File: doc/serializer_shift_right_8bit.md
Name: serializer_shift_right_8bit

Overview:
- Sequential parallel-to-serial stage that drives our 8-bit logical shift-right datapath.
- Accepts a byte over a valid/ready handshake and holds it in a shift register.
- Emits the byte LSB-first on a serial line, holding each bit for a programmable number of clocks.
- Each bit step is a logical shift right: the register shifts toward the LSB, the LSB is the serial carry-out, and zeros fill from the MSB.

Parameters:
- WIDTH, 8: data width in bits; must be 2 or more.
- CLKS_PER_BIT, 1: clock cycles each serial bit is held; must be 1 or more.
- CNT_W, 4: width of bit_idx; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load_valid  input  1  load_data is valid
- load_ready  output  1  block can accept a byte
- load_data  input  WIDTH  byte to serialize
- abort  input  1  synchronous cancel of the current transfer
- ser_out  output  1  serial data, LSB first
- ser_valid  output  1  ser_out carries a data bit
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse when the last bit period ends
- bit_idx  output  CNT_W  index of the bit currently on ser_out

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- While rst_n=0, all of the following hold immediately:
  - state=IDLE; shreg=0; bit_idx=0; div_cnt=0.
  - ser_out=0, ser_valid=0, busy=0, done=0, load_ready=1.
- States are IDLE and SHIFT. The registered done pulse is raised on the SHIFT→IDLE transition.
- IDLE:
  - load_ready=1, busy=0, ser_valid=0, ser_out=0.
  - A load is accepted at a rising edge with load_valid=1 and load_ready=1.
  - On accept: shreg<=load_data, bit_idx<=0, div_cnt<=0, state<=SHIFT.
- SHIFT:
  - load_ready=0, busy=1, ser_valid=1, ser_out=shreg[0].
  - Each clock: div_cnt increments.
  - When div_cnt=CLKS_PER_BIT-1:
    - div_cnt<=0.
    - shreg<={1'b0, shreg[WIDTH-1:1]} (logical right shift, zero fill).
    - bit_idx increments.
  - If that same edge ends bit_idx=WIDTH-1: state<=IDLE and done<=1 for exactly one cycle.
- Latency:
  - First bit appears the cycle after accept.
  - Each bit is held CLKS_PER_BIT cycles.
  - done is high in the first IDLE cycle.
  - Per-byte period is WIDTH*CLKS_PER_BIT+1 cycles. Back-to-back loads are accepted in the done cycle.
- load_valid while busy: ignored, no state change. The upstream holds its data.
- abort=1 in SHIFT:
  - Next state is IDLE; shreg<=0; bit_idx<=0; div_cnt<=0; no done pulse.
  - abort takes priority over a simultaneous final-bit completion, so done stays 0.
- abort=1 in IDLE: no effect. A simultaneous load is accepted normally.
- Reset asserted mid-transfer: immediate return to reset values; no done pulse, no partial output afterwards.
- shreg value:
  - shreg is zero after the last shift. It must not be sampled as data.
  - ser_out is forced to 0 whenever ser_valid=0.
- bit_idx wraps to 0 on return to IDLE and is never WIDTH while ser_valid=1.

Test Plan:
- Reset check: assert rst_n=0 mid-clock → all outputs reach reset values without a clock edge; load_ready=1.
- Basic transfer (CLKS_PER_BIT=1): load 8'b11111101.
  - ser_out over 8 cycles is 1,0,1,1,1,1,1,1 with bit_idx 0..7.
  - done=1 in cycle 9; busy=0 in cycle 9.
- Bit hold (CLKS_PER_BIT=3): load 8'b10001110.
  - Each bit is held 3 cycles: 0,1,1,1,0,0,0,1.
  - done occurs 25 cycles after accept.
- Back-to-back: load 8'b11001101, then keep load_valid high with 8'b10001111.
  - Second accept happens in the done cycle.
  - Serial stream is 1,0,1,1,0,0,1,1, then 1,1,1,1,0,0,0,1 with exactly one idle (ser_valid=0) cycle between.
- Busy ignore and abort:
  - Pulse load_valid with 8'h55 during transfer of 8'hAA → 8'hAA output unchanged.
  - abort at bit_idx=4 → ser_valid=0 next cycle, no done.
  - Next load 8'h01 serializes correctly.
- Simultaneous events:
  - abort on the final-bit edge → done stays 0.
  - rst_n low at bit_idx=3 → outputs reset; after release, a load of 8'hF0 yields 0,0,0,0,1,1,1,1.
